bsg_tielo_release_ctrl: RTL and testbench
=========================================

# bsg_tielo_release_ctrl

Sequencer that holds a bus tied low and releases it to live data in staged lane groups, with a programmable dwell between groups, then re-ties it in reverse order on command. It sits between a tie-low-protected datapath and its source, so downstream logic sees all-zero inputs until bring-up, and current steps stay bounded during release and quiesce. Parameterized width and group size; one clock domain.

## Interface
- width_p, 16, bus width in lanes (bits)
- group_p, 4, lanes released/re-tied per step; last group may be partial
- dwell_width_p, 8, width of dwell count

- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous active-low reset
- data_i  in  width_p  live data to be gated
- data_o  out  width_p  data_i & lanes_on_o (combinational)
- dwell_i  in  dwell_width_p  idle cycles between group steps; sampled only when a command is accepted
- up_v_i  in  1  request release (raise)
- down_v_i  in  1  request re-tie (lower)
- ready_o  out  1  controller at rest (OFF or ON)
- busy_o  out  1  sequence in progress (RAISE or LOWER)
- all_on_o  out  1  every lane released
- lanes_on_o  out  width_p  lane mask, 1 = released

## Operation
- Groups: G = ceil(width_p/group_p); group k = lanes [k*group_p, min((k+1)*group_p, width_p)-1].
- States: OFF, RAISE, ON, LOWER. Registers: state, group pointer, dwell counter, latched dwell d.
- OFF: mask 0, ready_o=1. up_v_i=1 at edge -> latch d=dwell_i, set group 0, load counter d, go RAISE (or ON if G=1).
- RAISE: counter decrements each cycle; at edge where counter is 0, set next group, reload d. Edge that sets group G-1 -> ON.
- ON: mask all ones, ready_o=1, all_on_o=1. down_v_i=1 at edge -> latch d, clear group G-1, go LOWER (or OFF if G=1).
- LOWER: mirror of RAISE, clearing groups from highest to lowest; edge clearing group 0 -> OFF.
- Reversal: down_v_i in RAISE -> at that edge clear highest set group, reload d, go LOWER (OFF if it was group 0). up_v_i in LOWER -> at that edge set lowest cleared group, reload d, go RAISE (ON if it was G-1). d not re-sampled on reversal.
- Simultaneous up_v_i and down_v_i: down wins. up_v_i in ON and down_v_i in OFF are ignored. Commands in RAISE matching current direction are ignored.
- mask is always a contiguous run of groups starting at group 0.
- busy_o = RAISE|LOWER; ready_o = ~busy_o; all_on_o = (mask == all ones).

## Timing
- Reset (async assert, any time incl. mid-sequence): lanes_on_o=0, data_o=0 immediately; state OFF, ready_o=1, busy_o=0, all_on_o=0, counter 0, d 0. Deassertion is synchronized externally; first command accepted on first edge after deassertion.
- Command accepted at edge E0: group k changes at edge E0 + k*(d+1); full sequence completes at E0 + (G-1)*(d+1); state ON/OFF and ready_o visible after that same edge.
- d=0: one group per cycle. d = 2^dwell_width_p - 1: max dwell, no overflow; counter saturates at 0 while not stepping.
- data_o follows data_i combinationally within a cycle; mask changes only on clock edges (or reset).

## Test plan
- Reset mid-sequence: width 16, group 4, d=3, assert reset_n_i low two cycles after up_v_i -> lanes_on_o=0x0000 immediately, ready_o=1, busy_o=0.
- Raise: d=2, up_v_i pulse at E0, data_i=0xFFFF -> data_o 0x000F after E0, 0x00FF after E3, 0x0FFF after E6, 0xFFFF and all_on_o=1, ready_o=1 after E9.
- Lower: from ON, d=0, down_v_i at E0 -> mask 0x0FFF, 0x00FF, 0x000F, 0x0000 after E0..E3; ready_o=1 after E3.
- Reversal: d=4, up at E0, down at E6 (mask 0x00FF) -> mask 0x000F after E6, 0x0000 after E11, state OFF.
- Partial group and conflicts: width_p=10, group_p=4, d=0, up_v_i and down_v_i both high in OFF -> no change; up alone -> mask 0x00F, 0x0FF, 0x3FF over three edges; up in ON ignored.
- Dwell sampling: change dwell_i from 1 to 7 during RAISE -> step spacing remains 2 cycles until completion.

Source files
------------

// File: rtl/bsg_tielo_release_ctrl_if.sv
// Gated-bus handshake for the tie-low release sequencer: live data, commands,
// dwell and status/mask back from the controller.
interface bsg_tielo_release_ctrl_if #(
    parameter int unsigned width_p       = 16,
    parameter int unsigned dwell_width_p = 8
);
    logic [width_p-1:0]       data_i;
    logic [width_p-1:0]       data_o;
    logic [dwell_width_p-1:0] dwell_i;
    logic                     up_v_i;
    logic                     down_v_i;
    logic                     ready_o;
    logic                     busy_o;
    logic                     all_on_o;
    logic [width_p-1:0]       lanes_on_o;

    modport master (
        output data_i, dwell_i, up_v_i, down_v_i,
        input  data_o, ready_o, busy_o, all_on_o, lanes_on_o
    );

    modport slave (
        input  data_i, dwell_i, up_v_i, down_v_i,
        output data_o, ready_o, busy_o, all_on_o, lanes_on_o
    );
endinterface

// File: rtl/bsg_tielo_release_ctrl.sv
// Staged tie-low release/re-tie sequencer: lanes are released group by group
// with a programmable dwell, and re-tied in reverse order on command.
module bsg_tielo_release_ctrl #(
    parameter int unsigned width_p       = 16,
    parameter int unsigned group_p       = 4,
    parameter int unsigned dwell_width_p = 8
) (
    input logic                       clk_i,
    input logic                       reset_n_i,
    bsg_tielo_release_ctrl_if.slave   io
);
    localparam int unsigned groups_lp = (width_p + group_p - 1) / group_p;
    localparam int unsigned ptr_w_lp  = $clog2(groups_lp + 1);

    typedef enum logic [1:0] {
        e_off,
        e_raise,
        e_on,
        e_lower
    } state_e;

    state_e                   state_r, state_n;
    // n_on_r counts released groups; the mask is always groups [0, n_on_r-1]
    logic [ptr_w_lp-1:0]      n_on_r, n_on_n;
    logic [dwell_width_p-1:0] cnt_r, cnt_n;
    logic [dwell_width_p-1:0] d_r, d_n;
    logic [width_p-1:0]       lanes_mask;

    wire logic up_only = io.up_v_i & ~io.down_v_i;
    wire logic at_top  = (n_on_r == ptr_w_lp'(groups_lp - 1));
    wire logic at_one  = (n_on_r == ptr_w_lp'(1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_off;
            n_on_r  <= '0;
            cnt_r   <= '0;
            d_r     <= '0;
        end else begin
            state_r <= state_n;
            n_on_r  <= n_on_n;
            cnt_r   <= cnt_n;
            d_r     <= d_n;
        end
    end

    always_comb begin
        state_n = state_r;
        n_on_n  = n_on_r;
        cnt_n   = cnt_r;
        d_n     = d_r;
        unique case (state_r)
            e_off: if (up_only) begin
                d_n     = io.dwell_i;
                cnt_n   = io.dwell_i;
                n_on_n  = ptr_w_lp'(1);
                state_n = (groups_lp == 1) ? e_on : e_raise;
            end
            e_on: if (io.down_v_i) begin
                d_n     = io.dwell_i;
                cnt_n   = io.dwell_i;
                n_on_n  = n_on_r - ptr_w_lp'(1);
                state_n = (groups_lp == 1) ? e_off : e_lower;
            end
            e_raise: begin
                // A reversal takes priority over a pending dwell expiry
                if (io.down_v_i) begin
                    n_on_n  = n_on_r - ptr_w_lp'(1);
                    cnt_n   = d_r;
                    state_n = at_one ? e_off : e_lower;
                end else if (cnt_r == '0) begin
                    n_on_n  = n_on_r + ptr_w_lp'(1);
                    cnt_n   = d_r;
                    if (at_top) state_n = e_on;
                end else begin
                    cnt_n = cnt_r - dwell_width_p'(1);
                end
            end
            e_lower: begin
                if (up_only) begin
                    n_on_n  = n_on_r + ptr_w_lp'(1);
                    cnt_n   = d_r;
                    state_n = at_top ? e_on : e_raise;
                end else if (cnt_r == '0) begin
                    n_on_n  = n_on_r - ptr_w_lp'(1);
                    cnt_n   = d_r;
                    if (at_one) state_n = e_off;
                end else begin
                    cnt_n = cnt_r - dwell_width_p'(1);
                end
            end
        endcase
    end

    always_comb begin
        lanes_mask = '0;
        for (int unsigned i = 0; i < width_p; i++) begin
            lanes_mask[i] = ((i / group_p) < 32'(n_on_r));
        end
    end

    assign io.lanes_on_o = lanes_mask;
    assign io.data_o     = io.data_i & lanes_mask;
    assign io.busy_o     = (state_r == e_raise) || (state_r == e_lower);
    assign io.ready_o    = ~io.busy_o;
    assign io.all_on_o   = (lanes_mask == '1);
endmodule

// File: tb/tb_bsg_tielo_release_ctrl.sv
// Bench for the tie-low release sequencer: a 16-lane and a 10-lane instance
// checked every cycle against a timestamp-based model plus directed literals.
module tb_bsg_tielo_release_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    bsg_tielo_release_ctrl_if #(.width_p(16), .dwell_width_p(8)) ifa ();
    bsg_tielo_release_ctrl_if #(.width_p(10), .dwell_width_p(8)) ifb ();

    bsg_tielo_release_ctrl #(.width_p(16), .group_p(4), .dwell_width_p(8)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .io(ifa.slave)
    );
    bsg_tielo_release_ctrl #(.width_p(10), .group_p(4), .dwell_width_p(8)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .io(ifb.slave)
    );

    // Model: number of released groups, direction of travel, cycle of last
    // change; a step is due exactly d+1 cycles after the previous change.
    typedef struct {
        int groups;
        int dir;
        int last;
        int d;
    } mdl_t;

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    function automatic mdl_t mdl_step(mdl_t s, int g, int now, logic up, logic down, int dwell);
        mdl_t r = s;
        if (s.dir == 0) begin
            if (down && s.groups == g) begin
                r.d = dwell; r.groups = s.groups - 1; r.last = now;
                r.dir = (r.groups == 0) ? 0 : -1;
            end else if (up && !down && s.groups == 0) begin
                r.d = dwell; r.groups = 1; r.last = now;
                r.dir = (r.groups == g) ? 0 : 1;
            end
        end else if (s.dir == 1 && down) begin
            r.groups = s.groups - 1; r.last = now;
            r.dir = (r.groups == 0) ? 0 : -1;
        end else if (s.dir == -1 && up && !down) begin
            r.groups = s.groups + 1; r.last = now;
            r.dir = (r.groups == g) ? 0 : 1;
        end else if (now - s.last == s.d + 1) begin
            r.groups = s.groups + s.dir; r.last = now;
            if (r.groups == 0 || r.groups == g) r.dir = 0;
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_mask(int groups, int gp, int w);
        logic [15:0] m = '0;
        int n = groups * gp;
        if (n > w) n = w;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= mdl_step(ma, 4, cyc, ifa.up_v_i, ifa.down_v_i, int'(ifa.dwell_i));
            mb <= mdl_step(mb, 3, cyc, ifb.up_v_i, ifb.down_v_i, int'(ifb.dwell_i));
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [15:0] em;
        em = exp_mask(ma.groups, 4, 16);
        chk("a_lanes", 32'(ifa.lanes_on_o), 32'(em));
        chk("a_data", 32'(ifa.data_o), 32'(ifa.data_i & em));
        chk("a_ready", 32'(ifa.ready_o), 32'(ma.dir == 0));
        chk("a_busy", 32'(ifa.busy_o), 32'(ma.dir != 0));
        chk("a_all_on", 32'(ifa.all_on_o), 32'(ma.groups == 4));
        em = exp_mask(mb.groups, 4, 10);
        chk("b_lanes", 32'(ifb.lanes_on_o), 32'(em));
        chk("b_data", 32'(ifb.data_o), 32'(ifb.data_i & em[9:0]));
        chk("b_ready", 32'(ifb.ready_o), 32'(mb.dir == 0));
        chk("b_busy", 32'(ifb.busy_o), 32'(mb.dir != 0));
        chk("b_all_on", 32'(ifb.all_on_o), 32'(mb.groups == 3));
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic up_a(int d);
        ifa.up_v_i = 1'b1; ifa.dwell_i = 8'(d);
        tick(1);
        ifa.up_v_i = 1'b0;
    endtask

    task automatic down_a(int d);
        ifa.down_v_i = 1'b1; ifa.dwell_i = 8'(d);
        tick(1);
        ifa.down_v_i = 1'b0;
    endtask

    initial begin
        ifa.data_i = '0; ifa.dwell_i = '0; ifa.up_v_i = 1'b0; ifa.down_v_i = 1'b0;
        ifb.data_i = '0; ifb.dwell_i = '0; ifb.up_v_i = 1'b0; ifb.down_v_i = 1'b0;
        tick(3);
        chk("rst_lanes", 32'(ifa.lanes_on_o), 32'h0);
        chk("rst_ready", 32'(ifa.ready_o), 32'h1);
        chk("rst_busy", 32'(ifa.busy_o), 32'h0);
        chk("rst_all_on", 32'(ifa.all_on_o), 32'h0);
        rst_n = 1'b1;

        // Reset two cycles into a raise
        ifa.data_i = 16'hFFFF;
        up_a(3);
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_lanes", 32'(ifa.lanes_on_o), 32'h0);
        chk("midrst_data", 32'(ifa.data_o), 32'h0);
        chk("midrst_ready", 32'(ifa.ready_o), 32'h1);
        chk("midrst_busy", 32'(ifa.busy_o), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Raise with d=2
        up_a(2);
        chk("raise_e0", 32'(ifa.data_o), 32'h000F);
        tick(2);
        chk("raise_e2", 32'(ifa.data_o), 32'h000F);
        tick(1);
        chk("raise_e3", 32'(ifa.data_o), 32'h00FF);
        tick(3);
        chk("raise_e6", 32'(ifa.data_o), 32'h0FFF);
        chk("raise_e6_busy", 32'(ifa.busy_o), 32'h1);
        tick(3);
        chk("raise_e9", 32'(ifa.data_o), 32'hFFFF);
        chk("raise_all_on", 32'(ifa.all_on_o), 32'h1);
        chk("raise_ready", 32'(ifa.ready_o), 32'h1);

        // Lower with d=0
        ifa.data_i = 16'hA5C3;
        down_a(0);
        chk("lower_e0", 32'(ifa.lanes_on_o), 32'h0FFF);
        chk("lower_e0_data", 32'(ifa.data_o), 32'h05C3);
        tick(1);
        chk("lower_e1", 32'(ifa.lanes_on_o), 32'h00FF);
        tick(1);
        chk("lower_e2", 32'(ifa.lanes_on_o), 32'h000F);
        tick(1);
        chk("lower_e3", 32'(ifa.lanes_on_o), 32'h0000);
        chk("lower_ready", 32'(ifa.ready_o), 32'h1);

        // Reversal RAISE -> LOWER with d=4
        up_a(4);
        tick(5);
        chk("rev_e5", 32'(ifa.lanes_on_o), 32'h00FF);
        down_a(9);
        chk("rev_e6", 32'(ifa.lanes_on_o), 32'h000F);
        tick(4);
        chk("rev_e10", 32'(ifa.lanes_on_o), 32'h000F);
        tick(1);
        chk("rev_e11", 32'(ifa.lanes_on_o), 32'h0000);
        chk("rev_ready", 32'(ifa.ready_o), 32'h1);

        // Dwell only sampled at command acceptance
        up_a(1);
        ifa.dwell_i = 8'd7;
        tick(2);
        chk("dwl_e2", 32'(ifa.lanes_on_o), 32'h00FF);
        tick(2);
        chk("dwl_e4", 32'(ifa.lanes_on_o), 32'h0FFF);
        tick(2);
        chk("dwl_e6", 32'(ifa.lanes_on_o), 32'hFFFF);

        // Reversal LOWER -> RAISE with d=1
        down_a(1);
        tick(2);
        chk("rev2_f2", 32'(ifa.lanes_on_o), 32'h00FF);
        up_a(0);
        chk("rev2_f3", 32'(ifa.lanes_on_o), 32'h0FFF);
        chk("rev2_f3_busy", 32'(ifa.busy_o), 32'h1);
        tick(2);
        chk("rev2_f5", 32'(ifa.lanes_on_o), 32'hFFFF);
        down_a(0);
        tick(3);

        // Both commands during RAISE: down wins
        up_a(1);
        tick(2);
        ifa.up_v_i = 1'b1; ifa.down_v_i = 1'b1;
        tick(1);
        ifa.up_v_i = 1'b0; ifa.down_v_i = 1'b0;
        chk("both_raise", 32'(ifa.lanes_on_o), 32'h000F);
        tick(2);
        chk("both_raise_off", 32'(ifa.lanes_on_o), 32'h0000);

        // Maximum dwell
        up_a(255);
        tick(255);
        chk("max_e255", 32'(ifa.lanes_on_o), 32'h000F);
        tick(1);
        chk("max_e256", 32'(ifa.lanes_on_o), 32'h00FF);
        down_a(0);
        tick(256);
        chk("max_off", 32'(ifa.lanes_on_o), 32'h0000);

        // Partial last group and command conflicts on the 10-lane instance
        ifb.data_i = 10'h2B7;
        ifb.up_v_i = 1'b1; ifb.down_v_i = 1'b1;
        tick(1);
        ifb.down_v_i = 1'b0;
        chk("b_both_off", 32'(ifb.lanes_on_o), 32'h000);
        ifb.dwell_i = '0;
        tick(1);
        ifb.up_v_i = 1'b0;
        chk("b_e0", 32'(ifb.lanes_on_o), 32'h00F);
        chk("b_e0_data", 32'(ifb.data_o), 32'h007);
        tick(1);
        chk("b_e1", 32'(ifb.lanes_on_o), 32'h0FF);
        tick(1);
        chk("b_e2", 32'(ifb.lanes_on_o), 32'h3FF);
        chk("b_all_on_lit", 32'(ifb.all_on_o), 32'h1);
        ifb.up_v_i = 1'b1;
        tick(1);
        ifb.up_v_i = 1'b0;
        chk("b_up_in_on", 32'(ifb.lanes_on_o), 32'h3FF);
        chk("b_ready_on", 32'(ifb.ready_o), 32'h1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
